// File: rtl/fetch_pkg.sv
// Shared definitions for the ROM fetch unit: state encoding, data widths and
// the pointer-width helper used to size the prefetch FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {PC, instruction} pairs. Flush empties it
// in one cycle; push and pop together leave the count unchanged.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iPUSH,
  input  logic             iPOP,
  input  logic             iFLUSH,
  input  logic [WIDTH-1:0] iDATA,
  output logic [WIDTH-1:0] oDATA,
  output logic [PTR_W:0]   oCOUNT,
  output logic             oFULL,
  output logic             oEMPTY
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  always_ff @(posedge iCLK) begin
    if (iRST || iFLUSH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (iPUSH) wrPtr <= wrPtr + 1'b1;
      if (iPOP)  rdPtr <= rdPtr + 1'b1;
      case ({iPUSH, iPOP})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge iCLK) begin
    if (iPUSH && !iFLUSH && !iRST) mem[wrPtr] <= iDATA;
  end

  assign oDATA  = mem[rdPtr];
  assign oCOUNT = count;
  assign oFULL  = (count == (PTR_W + 1)'(DEPTH));
  assign oEMPTY = (count == '0);

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction ROM fetch initiator: walks the PC, issues ROM reads into a
// prefetch FIFO and presents {PC, instr} to the core. Range-check fault: FETCH_FAULT_EN.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] ROM_ORIGIN = 32'h0,
  parameter logic [31:0] ROM_LENGTH = 32'h400,
  parameter int          FIFO_DEPTH = 4,
  localparam int         PTR_W      = clog2(FIFO_DEPTH)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  output logic               oROM_CE,
  output logic               oROM_RD,
  output logic [31:0]        oROM_ADDR,
  input  logic [INSTR_W-1:0] iROM_DATA,
  input  logic               iREDIRECT,
  input  logic [31:0]        iREDIRECT_PC,
  output logic               oINSTR_VALID,
  output logic [INSTR_W-1:0] oINSTR,
  output logic [31:0]        oINSTR_PC,
  input  logic               iINSTR_READY,
  output logic               oFAULT,
  output logic [1:0]         oDBG_STATE,
  output logic [PTR_W:0]     oDBG_COUNT
);

`ifdef FETCH_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  fetch_state_e   state, stateNext;
  logic [31:0]    pc;
  logic           inRange, issue, pop;
  logic           fifoFull, fifoEmpty;
  logic [63:0]    headData;

  assign inRange = (pc >= ROM_ORIGIN) && ((pc - ROM_ORIGIN) < ROM_LENGTH);

  // Handshake: the head transfers on a cycle where oINSTR_VALID and
  // iINSTR_READY are both high; VALID never depends on READY, and a redirect
  // cycle transfers nothing.
  always_comb begin
    pop       = oINSTR_VALID && iINSTR_READY && !iREDIRECT;
    issue     = (state == ST_RUN) && !iREDIRECT && (!fifoFull || pop) &&
                (inRange || !FAULT_EN);
    stateNext = state;
    if (iREDIRECT) begin
      stateNext = iEN ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (iEN) stateNext = ST_RUN;
        ST_RUN: begin
          if (FAULT_EN && !inRange) stateNext = ST_FAULT;
          else if (!iEN)            stateNext = ST_IDLE;
        end
        ST_FAULT: stateNext = ST_FAULT;
        default:  stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= stateNext;
      if (iREDIRECT)  pc <= {iREDIRECT_PC[31:2], 2'b00};
      else if (issue) pc <= pc + PC_INC;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iPUSH  (issue),
    .iPOP   (pop),
    .iFLUSH (iREDIRECT),
    .iDATA  ({pc, iROM_DATA}),
    .oDATA  (headData),
    .oCOUNT (oDBG_COUNT),
    .oFULL  (fifoFull),
    .oEMPTY (fifoEmpty)
  );

  assign oROM_CE      = issue;
  assign oROM_RD      = issue;
  assign oROM_ADDR    = pc;
  assign oINSTR_VALID = !fifoEmpty;
  assign oINSTR_PC    = oINSTR_VALID ? headData[63:32] : 32'h0;
  assign oINSTR       = oINSTR_VALID ? headData[31:0]  : 32'h0;
  assign oFAULT       = FAULT_EN && (state == ST_FAULT);
  assign oDBG_STATE   = state;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed latency/backpressure/redirect/reset
// scenarios plus a randomized phase, checked by an in-order stream scoreboard.
module tb_rom_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        iCLK = 1'b0;
  logic        iRST, iEN, iREDIRECT, iINSTR_READY;
  logic [31:0] iREDIRECT_PC, iROM_DATA;
  logic        oROM_CE, oROM_RD, oINSTR_VALID, oFAULT;
  logic [31:0] oROM_ADDR, oINSTR, oINSTR_PC;
  logic [1:0]  oDBG_STATE;
  logic [2:0]  oDBG_COUNT;

  int checks    = 0;
  int failures  = 0;
  int hs_count  = 0;
  logic [63:0] exp_q[$];

  always #5 iCLK = ~iCLK;

  rom_fetch_unit dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iEN          (iEN),
    .oROM_CE      (oROM_CE),
    .oROM_RD      (oROM_RD),
    .oROM_ADDR    (oROM_ADDR),
    .iROM_DATA    (iROM_DATA),
    .iREDIRECT    (iREDIRECT),
    .iREDIRECT_PC (iREDIRECT_PC),
    .oINSTR_VALID (oINSTR_VALID),
    .oINSTR       (oINSTR),
    .oINSTR_PC    (oINSTR_PC),
    .iINSTR_READY (iINSTR_READY),
    .oFAULT       (oFAULT),
    .oDBG_STATE   (oDBG_STATE),
    .oDBG_COUNT   (oDBG_COUNT)
  );

  // ROM contents: word i of the 1 KiB window holds 0x1000_0000 + i.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr < 32'h400) return 32'h1000_0000 + (addr >> 2);
    return 32'h0;
  endfunction

  always_comb iROM_DATA = rom_word(oROM_ADDR);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // After a reset or redirect the core must see a contiguous word stream from the new PC.
  task automatic start_stream(input logic [31:0] start_pc);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = start_pc + 32'(i * 4);
      exp_q.push_back({p, rom_word(p)});
    end
  endtask

  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b1; iREDIRECT = 1'b0; iEN = 1'b0; iINSTR_READY = 1'b0;
    start_stream(RESET_PC);
    next_cycle();
    iRST = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    iREDIRECT = 1'b1;
    iREDIRECT_PC = target;
    start_stream({target[31:2], 2'b00});
  endtask

  // Monitor: every accepted head must be the next word of the expected stream.
  always @(negedge iCLK) begin
    if (!iRST && !iREDIRECT && oINSTR_VALID && iINSTR_READY) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_unexpected actual=%0h required=none", {oINSTR_PC, oINSTR});
      end else begin
        chk("stream_entry", {oINSTR_PC, oINSTR}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    iREDIRECT_PC = 32'h0;
    do_reset();
    settle();
    chk("rst_valid", oINSTR_VALID, 0);
    chk("rst_ce", {oROM_CE, oROM_RD}, 0);
    chk("rst_addr", oROM_ADDR, RESET_PC);
    chk("rst_fault", oFAULT, 0);
    chk("rst_instr", {oINSTR_PC, oINSTR}, 0);
    chk("rst_state", oDBG_STATE, 0);

    // Latency and throughput from enable.
    iEN = 1'b1; iINSTR_READY = 1'b1;
    settle();
    chk("lat_idle_ce", oROM_CE, 0);
    next_cycle(); settle();
    chk("lat_first_ce", {oROM_CE, oROM_RD}, 2'b11);
    chk("lat_first_addr", oROM_ADDR, 32'h0);
    chk("lat_first_valid", oINSTR_VALID, 0);
    next_cycle(); settle();
    chk("lat_valid", oINSTR_VALID, 1);
    chk("lat_head_pc", oINSTR_PC, 32'h0);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
      chk("tput_valid", oINSTR_VALID, 1);
      chk("tput_ce", oROM_CE, 1);
    end

    // Backpressure: exactly FIFO_DEPTH issues, then resume at 0x10 on pop.
    do_reset();
    iEN = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (oROM_CE) n++;
      next_cycle();
    end
    chk("bp_issue_count", 32'(n), 4);
    chk("bp_full_count", oDBG_COUNT, 4);
    chk("bp_addr_held", oROM_ADDR, 32'h10);
    chk("bp_head_pc", oINSTR_PC, 32'h0);
    iINSTR_READY = 1'b1;
    settle();
    chk("bp_resume_ce", oROM_CE, 1);
    chk("bp_resume_addr", oROM_ADDR, 32'h10);
    repeat (8) next_cycle();

    // Redirect with three entries queued: no stale entry reaches the core.
    do_reset();
    iEN = 1'b1;
    repeat (4) next_cycle();
    chk("redir_pre_count", oDBG_COUNT, 3);
    redirect_to(32'h40);
    iINSTR_READY = 1'b1;
    settle();
    chk("redir_no_ce", oROM_CE, 0);
    next_cycle();
    iREDIRECT = 1'b0;
    settle();
    chk("redir_flushed", oINSTR_VALID, 0);
    chk("redir_ce_addr", {31'b0, oROM_CE, oROM_ADDR}, {32'h1, 32'h40});
    next_cycle(); settle();
    chk("redir_head", {oINSTR_VALID, oINSTR_PC, oINSTR}, {1'b1, 32'h40, 32'h1000_0010});
    repeat (5) next_cycle();

    // Enable dropped mid-stream: contents kept and drained, fetch resumes.
    iINSTR_READY = 1'b0;
    repeat (2) next_cycle();
    iEN = 1'b0;
    next_cycle(); settle();
    chk("en_off_ce", oROM_CE, 0);
    chk("en_off_state", oDBG_STATE, 0);
    chk("en_off_kept", oINSTR_VALID, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); settle();
      chk("en_off_idle_ce", oROM_CE, 0);
    end
    iINSTR_READY = 1'b1;
    repeat (6) next_cycle();
    settle();
    chk("en_off_drained", oINSTR_VALID, 0);
    iEN = 1'b1;
    next_cycle(); settle();
    chk("en_resume_ce", oROM_CE, 1);
    repeat (4) next_cycle();

    // Reset beats a simultaneous redirect with a full FIFO.
    iINSTR_READY = 1'b0;
    repeat (6) next_cycle();
    chk("rst_mid_full", oDBG_COUNT, 4);
    iRST = 1'b1;
    iREDIRECT = 1'b1; iREDIRECT_PC = 32'h80;
    start_stream(RESET_PC);
    next_cycle();
    iRST = 1'b0; iREDIRECT = 1'b0; iEN = 1'b0;
    settle();
    chk("rst_mid_valid", oINSTR_VALID, 0);
    chk("rst_mid_ce", oROM_CE, 0);
    chk("rst_mid_addr", oROM_ADDR, RESET_PC);
    chk("rst_mid_state", oDBG_STATE, 0);

`ifdef FETCH_FAULT_EN
    // Fetching past the window end faults; a redirect clears it.
    do_reset();
    iEN = 1'b1; iINSTR_READY = 1'b1;
    redirect_to(32'h3FC);
    next_cycle();
    iREDIRECT = 1'b0;
    settle();
    chk("flt_last_ce", {31'b0, oROM_CE, oROM_ADDR}, {32'h1, 32'h3FC});
    next_cycle(); settle();
    chk("flt_edge_ce", oROM_CE, 0);
    chk("flt_edge_head", {oINSTR_PC, oINSTR}, {32'h3FC, 32'h1000_00FF});
    next_cycle(); settle();
    chk("flt_set", oFAULT, 1);
    chk("flt_no_ce", oROM_CE, 0);
    chk("flt_state", oDBG_STATE, 2);
    redirect_to(32'h0);
    next_cycle();
    iREDIRECT = 1'b0;
    settle();
    chk("flt_cleared", oFAULT, 0);
    chk("flt_restart", {31'b0, oROM_CE, oROM_ADDR}, {32'h1, 32'h0});
    repeat (4) next_cycle();
`endif

    // Randomized segments: random enable/ready, redirects to random (possibly unaligned) targets.
    do_reset();
    for (int s = 0; s < 40; s++) begin
      iEN = ($urandom_range(0, 9) != 0);
      iINSTR_READY = ($urandom_range(0, 3) != 0);
      redirect_to(32'($urandom_range(0, 32'h2FF)));
      next_cycle();
      iREDIRECT = 1'b0;
      n = $urandom_range(5, 40);
      for (int c = 0; c < n; c++) begin
        iEN = ($urandom_range(0, 9) != 0);
        iINSTR_READY = ($urandom_range(0, 3) != 0);
        next_cycle();
      end
    end
    iEN = 1'b0; iINSTR_READY = 1'b1;
    repeat (8) next_cycle();
    settle();
    chk("final_drained", oINSTR_VALID, 0);
    checks++;
    if (hs_count < 200) begin
      failures++;
      $display("FAIL handshake_total actual=%0d required=>=200", hs_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
